segment_scan_ctrl: RTL and testbench

Time-multiplexed scan controller for a multi-digit common-anode 7-segment display. It holds a BCD word and cycles through the digits, one slot per digit. Each slot drives one active-low anode together with that digit's segment pattern, with a blanking gap between slots to prevent ghosting. It sits between the number-producing logic (counters, ALU results) and the board's segment/anode pins.

---
 rtl/segment_scan_ctrl_if.sv | 24 ++
 rtl/segment_scan_ctrl.sv | 157 +++++++++++++++
 tb/tb_segment_scan_ctrl.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/segment_scan_ctrl_if.sv
// Load/display bundle between the number source, the scan controller and the board pins.
// The master drives the value, strobe and options; the slave drives the segment and anode pins.
interface segment_scan_ctrl_if #(
   parameter int DIGITS = 4
);
   logic [4*DIGITS-1:0] i_val;
   logic                i_load;
   logic [DIGITS-1:0]   i_dp;
   logic                i_lz_en;
   logic [6:0]          o_seg;
   logic                o_dp;
   logic [DIGITS-1:0]   o_an;
   logic                o_frame;

   modport master (
      output i_val, i_load, i_dp, i_lz_en,
      input  o_seg, o_dp, o_an, o_frame
   );

   modport slave (
      input  i_val, i_load, i_dp, i_lz_en,
      output o_seg, o_dp, o_an, o_frame
   );
endinterface

// File: rtl/segment_scan_ctrl.sv
// Multiplexed common-anode 7-segment scanner; all pins registered, one slot per digit.
// A load is held in a shadow and shown from the next frame wrap; the strobe is never stalled.
module segment_scan_ctrl #(
   parameter int DIGITS   = 4,
   parameter int TICK_DIV = 50000,
   parameter int BLANK    = 16
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   segment_scan_ctrl_if.slave bus
);
   localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);
   localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

   typedef enum logic {ST_BLANK, ST_SHOW} state_t;

   state_t              state;
   state_t              state_nxt;
   logic [CW-1:0]       cnt;
   logic [IW-1:0]       idx;
   logic [4*DIGITS-1:0] shadow_val;
   logic [4*DIGITS-1:0] active_val;
   logic [DIGITS-1:0]   shadow_dp;
   logic [DIGITS-1:0]   active_dp;
   logic                slot_end;
   logic                frame_wrap;
   logic                in_blank;
   logic                zero_run;
   logic [DIGITS-1:0]   suppress;
   logic [3:0]          cur_digit;
   logic                cur_dp;
   logic                cur_supp;
   logic [DIGITS-1:0]   an_nxt;
   logic [6:0]          seg_nxt;
   logic                dp_nxt;

   function automatic logic [6:0] seg_decode(input logic [3:0] d);
      case (d)
         4'd0:    seg_decode = 7'b1000000;
         4'd1:    seg_decode = 7'b1111001;
         4'd2:    seg_decode = 7'b0100100;
         4'd3:    seg_decode = 7'b0110000;
         4'd4:    seg_decode = 7'b0011001;
         4'd5:    seg_decode = 7'b0010010;
         4'd6:    seg_decode = 7'b0000010;
         4'd7:    seg_decode = 7'b1111000;
         4'd8:    seg_decode = 7'b0000000;
         4'd9:    seg_decode = 7'b0010000;
         default: seg_decode = 7'b1111111;
      endcase
   endfunction

   // cnt/idx name the position that the next edge puts on the pins.
   assign slot_end   = (cnt == CNT_LAST);
   assign frame_wrap = slot_end && (idx == IDX_LAST);

   generate
      if (BLANK == 0) begin : g_noblank
         assign in_blank = 1'b0;
      end else begin : g_blank
         assign in_blank = (cnt < CW'(BLANK));
      end
   endgenerate

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         cnt <= '0;
         idx <= '0;
      end else if (slot_end) begin
         cnt <= '0;
         idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   // A load on the wrap edge bypasses the shadow so it is not a frame late.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         shadow_val <= '0;
         shadow_dp  <= '0;
         active_val <= '0;
         active_dp  <= '0;
      end else begin
         if (bus.i_load) begin
            shadow_val <= bus.i_val;
            shadow_dp  <= bus.i_dp;
         end
         if (frame_wrap) begin
            active_val <= bus.i_load ? bus.i_val : shadow_val;
            active_dp  <= bus.i_load ? bus.i_dp  : shadow_dp;
         end
      end
   end

   always_comb begin
      zero_run = bus.i_lz_en;
      suppress = '0;
      for (int k = DIGITS - 1; k >= 1; k--) begin
         zero_run    = zero_run && (active_val[4*k +: 4] == 4'd0);
         suppress[k] = zero_run;
      end
   end

   always_comb begin
      cur_digit = 4'd0;
      cur_dp    = 1'b0;
      cur_supp  = 1'b0;
      for (int k = 0; k < DIGITS; k++) begin
         if (idx == IW'(k)) begin
            cur_digit = active_val[4*k +: 4];
            cur_dp    = active_dp[k];
            cur_supp  = suppress[k];
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state <= ST_BLANK;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = in_blank ? ST_BLANK : ST_SHOW;
      an_nxt    = '1;
      seg_nxt   = 7'b1111111;
      dp_nxt    = 1'b1;
      if (state_nxt == ST_SHOW) begin
         for (int k = 0; k < DIGITS; k++) begin
            if (idx == IW'(k)) begin
               an_nxt[k] = 1'b0;
            end
         end
         seg_nxt = cur_supp ? 7'b1111111 : seg_decode(cur_digit);
         dp_nxt  = ~cur_dp;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         bus.o_an    <= '1;
         bus.o_seg   <= 7'b1111111;
         bus.o_dp    <= 1'b1;
         bus.o_frame <= 1'b0;
      end else begin
         bus.o_an    <= an_nxt;
         bus.o_seg   <= seg_nxt;
         bus.o_dp    <= dp_nxt;
         bus.o_frame <= frame_wrap;
      end
   end
endmodule

// File: tb/tb_segment_scan_ctrl.sv
// Scoreboard bench: expected digit slots are queued per frame, a negedge monitor pops and compares.
module tb_segment_scan_ctrl;
   localparam logic [6:0] C0 = 7'b1000000;
   localparam logic [6:0] C1 = 7'b1111001;
   localparam logic [6:0] C2 = 7'b0100100;
   localparam logic [6:0] C3 = 7'b0110000;
   localparam logic [6:0] C4 = 7'b0011001;
   localparam logic [6:0] C5 = 7'b0010010;
   localparam logic [6:0] C6 = 7'b0000010;
   localparam logic [6:0] C7 = 7'b1111000;
   localparam logic [6:0] C8 = 7'b0000000;
   localparam logic [6:0] C9 = 7'b0010000;
   localparam logic [6:0] CB = 7'b1111111;

   typedef struct {
      logic [3:0] an;
      logic [6:0] seg;
      logic       dp;
   } slot_t;

   logic clk = 1'b0;
   logic rst_n;
   logic rst6_n;
   logic done6 = 1'b0;
   int   compared = 0;
   int   mismatched = 0;
   slot_t exp_q[$];

   always #5 clk = ~clk;

   segment_scan_ctrl_if #(.DIGITS(4)) bus ();
   segment_scan_ctrl_if #(.DIGITS(4)) bus6 ();

   segment_scan_ctrl #(.DIGITS(4), .TICK_DIV(8), .BLANK(2)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .bus(bus.slave)
   );
   segment_scan_ctrl #(.DIGITS(4), .TICK_DIV(3), .BLANK(0)) dut6 (
      .i_clk(clk), .i_rst_n(rst6_n), .bus(bus6.slave)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0b expected %0b", name, act, exp);
      end
   endtask

   task automatic push_frame(input logic [6:0] s0, input logic [6:0] s1, input logic [6:0] s2,
                             input logic [6:0] s3, input logic [3:0] dpn);
      slot_t s;
      s.an = 4'b1110; s.seg = s0; s.dp = dpn[0]; exp_q.push_back(s);
      s.an = 4'b1101; s.seg = s1; s.dp = dpn[1]; exp_q.push_back(s);
      s.an = 4'b1011; s.seg = s2; s.dp = dpn[2]; exp_q.push_back(s);
      s.an = 4'b0111; s.seg = s3; s.dp = dpn[3]; exp_q.push_back(s);
   endtask

   task automatic load(input logic [15:0] v, input logic [3:0] d);
      @(posedge clk); #1;
      bus.i_val  = v;
      bus.i_dp   = d;
      bus.i_load = 1'b1;
      @(posedge clk); #1;
      bus.i_load = 1'b0;
   endtask

   task automatic wait_frame(input string name);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!bus.o_frame && n < 80);
      check(name, bus.o_frame, 1'b1);
   endtask

   task automatic release_check();
      int n = 0;
      bit seen = 1'b0;
      @(negedge clk); #2;
      rst_n = 1'b1;
      do begin
         @(negedge clk);
         n++;
         if (!seen && bus.o_an != 4'hF) begin
            seen = 1'b1;
            check("restart_cycle", n, 3);
            check("restart_an", bus.o_an, 4'b1110);
         end
      end while (!bus.o_frame && n < 80);
      check("first_frame_cycle", n, 32);
   endtask

   // Monitor: one-hot anodes, frame period, and per-slot compare against the queue.
   int         cyc = 0;
   int         last_frame = -1;
   int         blank_run = 0;
   int         show_run = 0;
   logic       armed = 1'b0;
   logic [3:0] prev_an = 4'hF;
   slot_t      e;

   always @(negedge clk) begin
      if (!rst_n) begin
         last_frame = -1;
         blank_run  = 0;
         show_run   = 0;
         armed      = 1'b0;
         prev_an    = 4'hF;
      end else begin
         cyc++;
         check("an_onehot", ($countones(~bus.o_an) <= 1), 1'b1);
         if (bus.o_frame) begin
            if (last_frame >= 0) check("frame_period", cyc - last_frame, 32);
            last_frame = cyc;
         end
         if (bus.o_an != prev_an && prev_an != 4'hF) begin
            if (armed) check("show_len", show_run, 6);
            armed = 1'b0;
         end
         if (bus.o_an == 4'hF) begin
            blank_run++;
            show_run = 0;
         end else begin
            if (bus.o_an != prev_an) begin
               if (exp_q.size() > 0) begin
                  e = exp_q.pop_front();
                  check("blank_len", blank_run, 2);
                  check("slot_an", bus.o_an, e.an);
                  armed = 1'b1;
               end
               show_run = 0;
            end
            if (armed) check("slot_seg_dp", {bus.o_seg, bus.o_dp}, {e.seg, e.dp});
            show_run++;
            blank_run = 0;
         end
         prev_an = bus.o_an;
      end
   end

   initial begin
      int n;
      rst_n       = 1'b0;
      bus.i_val   = '0;
      bus.i_dp    = '0;
      bus.i_load  = 1'b0;
      bus.i_lz_en = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_an", bus.o_an, 4'hF);
      check("rst_seg", bus.o_seg, CB);
      check("rst_dp", bus.o_dp, 1'b1);
      check("rst_frame", bus.o_frame, 1'b0);
      release_check();

      // 0x1234, then a mid-frame load, then a load exactly on the wrap edge
      repeat (4) @(posedge clk);
      load(16'h1234, 4'h0);
      wait_frame("t1_frame");
      push_frame(C4, C3, C2, C1, 4'hF);
      repeat (8) @(posedge clk);
      load(16'h5678, 4'h0);
      wait_frame("t2_frame");
      push_frame(C8, C7, C6, C5, 4'hF);
      repeat (30) @(posedge clk);
      load(16'h9999, 4'h0);
      wait_frame("t2_wrap_frame");
      push_frame(C9, C9, C9, C9, 4'hF);

      // leading-zero suppression; code 10 counts as nonzero and stops it
      bus.i_lz_en = 1'b1;
      repeat (8) @(posedge clk);
      load(16'h0070, 4'h0);
      wait_frame("t3_frame_0070");
      push_frame(C0, C7, CB, CB, 4'hF);
      repeat (8) @(posedge clk);
      load(16'h0000, 4'h0);
      wait_frame("t3_frame_0000");
      push_frame(C0, CB, CB, CB, 4'hF);
      repeat (8) @(posedge clk);
      load(16'h0A05, 4'b0100);
      wait_frame("t4_frame");
      push_frame(C5, C0, CB, CB, 4'b1011);
      wait_frame("t4_done");
      bus.i_lz_en = 1'b0;
      check("queue_drained_t4", exp_q.size(), 0);

      // async reset in the middle of digit 2
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (bus.o_an != 4'b1011 && n < 40);
      check("t5_reach_digit2", bus.o_an, 4'b1011);
      #2 rst_n = 1'b0;
      #1;
      check("t5_async_an", bus.o_an, 4'hF);
      check("t5_async_seg", bus.o_seg, CB);
      check("t5_async_dp", bus.o_dp, 1'b1);
      check("t5_async_frame", bus.o_frame, 1'b0);
      repeat (2) @(negedge clk);
      release_check();
      push_frame(C0, C0, C0, C0, 4'hF);
      wait_frame("t5_frame");
      repeat (2) @(negedge clk);
      check("queue_drained", exp_q.size(), 0);

      n = 0;
      while (!done6 && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("t6_done", done6, 1'b1);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   // No-blanking instance: each anode low for exactly 3 cycles, never all off.
   initial begin
      logic [3:0] e6;
      rst6_n       = 1'b0;
      bus6.i_val   = '0;
      bus6.i_dp    = '0;
      bus6.i_load  = 1'b0;
      bus6.i_lz_en = 1'b0;
      repeat (3) @(negedge clk);
      #2 rst6_n = 1'b1;
      for (int n = 0; n < 36; n++) begin
         @(negedge clk);
         e6 = ~(4'b0001 << ((n / 3) % 4));
         check("t6_not_blank", (bus6.o_an != 4'hF), 1'b1);
         check("t6_an", bus6.o_an, e6);
         check("t6_frame", bus6.o_frame, ((n % 12) == 11));
      end
      done6 = 1'b1;
   end
endmodule
